// File: rtl/button_event_scheduler_if.sv
// rtl/button_event_scheduler_if.sv - event port shared by all buttons: valid/ready with button index and event code
interface button_event_scheduler_if;
   logic       evt_valid;
   logic       evt_ready;
   logic [2:0] evt_btn;
   logic [1:0] evt_code;

   modport master (output evt_valid, output evt_btn, output evt_code, input evt_ready);
   modport slave  (input evt_valid, input evt_btn, input evt_code, output evt_ready);
endinterface

// File: rtl/button_event_scheduler.sv
// rtl/button_event_scheduler.sv - per-button SHORT/LONG/DOUBLE classifier, 1-deep pending slots, round-robin event port
// Optional auto-repeat while held: define BTN_AUTOREPEAT_EN.
module button_event_scheduler #(
   parameter int N_BTN         = 4,
   parameter int LONG_CYCLES   = 50000000,
   parameter int DBL_WINDOW    = 25000000,
   parameter int REPEAT_CYCLES = 10000000,
   parameter int CNT_W         = 27
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_BTN-1:0]     btn_p_edge_i,
   input  logic [N_BTN-1:0]     btn_n_edge_i,
   input  logic                 ovf_clr_i,
   output logic [N_BTN-1:0]     ovf_o,
   button_event_scheduler_if.master evt
);

   if (N_BTN < 2 || N_BTN > 8 || LONG_CYCLES < 2 || DBL_WINDOW < 2 || REPEAT_CYCLES < 1 ||
       64'(LONG_CYCLES) > (64'd1 << CNT_W) || 64'(DBL_WINDOW) > (64'd1 << CNT_W) ||
       64'(REPEAT_CYCLES) > (64'd1 << CNT_W)) begin : g_bad_cfg
      $error("button_event_scheduler: illegal parameter set");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRESS1,
      S_HELD,
      S_GAP,
      S_PRESS2
   } state_t;

   localparam logic [1:0] CODE_REPEAT = 2'b00;
   localparam logic [1:0] CODE_SHORT  = 2'b01;
   localparam logic [1:0] CODE_LONG   = 2'b10;
   localparam logic [1:0] CODE_DOUBLE = 2'b11;

   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_WINDOW - 1);
`ifdef BTN_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

   state_t           state_q   [N_BTN];
   state_t           state_d   [N_BTN];
   logic [CNT_W-1:0] cnt_q     [N_BTN];
   logic [CNT_W-1:0] cnt_d     [N_BTN];
   logic [1:0]       post_code [N_BTN];
   logic [1:0]       slot_code_q [N_BTN];
   logic [N_BTN-1:0] post_vld;
   logic [N_BTN-1:0] slot_full_q;
   logic [N_BTN-1:0] ovf_q;
   logic [N_BTN-1:0] drain;
   logic [N_BTN-1:0] p_eff;
   logic [N_BTN-1:0] n_eff;

   logic             evt_valid_q;
   logic [2:0]       evt_btn_q;
   logic [1:0]       evt_code_q;
   logic [2:0]       last_q;

   logic             load;
   logic             found;
   logic [2:0]       sel;
   logic [1:0]       sel_code;

   // A release pulse coinciding with a press pulse means the press was a glitch.
   assign p_eff = btn_p_edge_i & ~btn_n_edge_i;
   assign n_eff = btn_n_edge_i;

   always_comb begin
      for (int i = 0; i < N_BTN; i++) begin
         state_d[i]   = state_q[i];
         cnt_d[i]     = (cnt_q[i] == CNT_MAX) ? cnt_q[i] : cnt_q[i] + 1'b1;
         post_vld[i]  = 1'b0;
         post_code[i] = CODE_SHORT;
         case (state_q[i])
            S_IDLE: begin
               cnt_d[i] = '0;
               if (p_eff[i]) state_d[i] = S_PRESS1;
            end
            S_PRESS1: begin
               if (n_eff[i]) begin
                  state_d[i] = S_GAP;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == LONG_LAST) begin
                  state_d[i]   = S_HELD;
                  cnt_d[i]     = '0;
                  post_vld[i]  = 1'b1;
                  post_code[i] = CODE_LONG;
               end
            end
            S_HELD: begin
               if (n_eff[i]) begin
                  state_d[i] = S_IDLE;
                  cnt_d[i]   = '0;
               end else begin
`ifdef BTN_AUTOREPEAT_EN
                  if (cnt_q[i] == REP_LAST) begin
                     cnt_d[i]     = '0;
                     post_vld[i]  = 1'b1;
                     post_code[i] = CODE_REPEAT;
                  end
`else
                  cnt_d[i] = '0;
`endif
               end
            end
            S_GAP: begin
               if (p_eff[i]) begin
                  state_d[i] = S_PRESS2;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == DBL_LAST) begin
                  state_d[i]   = S_IDLE;
                  cnt_d[i]     = '0;
                  post_vld[i]  = 1'b1;
                  post_code[i] = CODE_SHORT;
               end
            end
            S_PRESS2: begin
               if (n_eff[i]) begin
                  state_d[i]   = S_IDLE;
                  cnt_d[i]     = '0;
                  post_vld[i]  = 1'b1;
                  post_code[i] = CODE_DOUBLE;
               end else if (cnt_q[i] == LONG_LAST) begin
                  state_d[i]   = S_HELD;
                  cnt_d[i]     = '0;
                  post_vld[i]  = 1'b1;
                  post_code[i] = CODE_DOUBLE;
               end
            end
            default: begin
               state_d[i] = S_IDLE;
               cnt_d[i]   = '0;
            end
         endcase
      end
   end

   // Round robin: lowest full slot above last wins, otherwise wrap to lowest full slot.
   always_comb begin
      load     = ~evt_valid_q | evt.evt_ready;
      found    = 1'b0;
      sel      = '0;
      sel_code = CODE_SHORT;
      for (int i = N_BTN - 1; i >= 0; i--) begin
         if (slot_full_q[i]) begin
            found    = 1'b1;
            sel      = 3'(i);
            sel_code = slot_code_q[i];
         end
      end
      for (int i = N_BTN - 1; i >= 0; i--) begin
         if (slot_full_q[i] && (3'(i) > last_q)) begin
            sel      = 3'(i);
            sel_code = slot_code_q[i];
         end
      end
      for (int i = 0; i < N_BTN; i++) begin
         drain[i] = load & found & (sel == 3'(i));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_BTN; i++) begin
            state_q[i]     <= S_IDLE;
            cnt_q[i]       <= '0;
            slot_code_q[i] <= CODE_REPEAT;
         end
         slot_full_q <= '0;
         ovf_q       <= '0;
      end else begin
         for (int i = 0; i < N_BTN; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
            if (post_vld[i] && (!slot_full_q[i] || drain[i])) begin
               slot_full_q[i] <= 1'b1;
               slot_code_q[i] <= post_code[i];
            end else if (drain[i]) begin
               slot_full_q[i] <= 1'b0;
            end
            if (post_vld[i] && slot_full_q[i] && !drain[i]) begin
               ovf_q[i] <= 1'b1;
            end else if (ovf_clr_i) begin
               ovf_q[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         evt_valid_q <= 1'b0;
         evt_btn_q   <= '0;
         evt_code_q  <= '0;
         last_q      <= 3'(N_BTN - 1);
      end else if (load) begin
         evt_valid_q <= found;
         if (found) begin
            evt_btn_q  <= sel;
            evt_code_q <= sel_code;
            last_q     <= sel;
         end
      end
   end

   assign evt.evt_valid = evt_valid_q;
   assign evt.evt_btn   = evt_btn_q;
   assign evt.evt_code  = evt_code_q;
   assign ovf_o         = ovf_q;

endmodule
